interval_meter: RTL and testbench

- Count-up counterpart of the countdown timer: measures elapsed tick periods between a start event and a stop event.
- Presents the captured interval through a valid/ack handshake.
- Sits beside countdown timers in the timer block. Used for pulse-width and latency measurement, and for checking programmed countdown periods.

---
 rtl/interval_meter_pkg.sv | 20 ++
 rtl/interval_meter_sat_counter.sv | 45 ++++
 rtl/interval_meter.sv | 115 +++++++++++
 tb/tb_interval_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/interval_meter_pkg.sv
// Shared timer definitions: FSM state encoding and a saturating-increment helper
// usable by any counter up to 32 bits wide.
package interval_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns v+1 when en is set and v is below the w-bit ceiling, otherwise v.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w,
                                            input logic en);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (en && (v < max_v)) ? (v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/interval_meter_sat_counter.sv
// W-bit up-counter with synchronous clear, saturation at all-ones and a sticky
// overflow flag; also exposes its next-state values for same-cycle capture.
module interval_meter_sat_counter
    import interval_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_ovf,
    output logic [W-1:0] o_next_count,
    output logic         o_next_ovf
);

    logic [W-1:0] r_count;
    logic         r_ovf;
    logic [W-1:0] w_next_count;
    logic         w_next_ovf;

    assign w_next_count = W'(sat_inc(32'(r_count), W, i_en));
    // An increment attempted while already at the ceiling marks overflow.
    assign w_next_ovf   = r_ovf | (i_en & (r_count == '1));

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_ovf   <= w_next_ovf;
        end
    end

    assign o_count      = r_count;
    assign o_ovf        = r_ovf;
    assign o_next_count = w_next_count;
    assign o_next_ovf   = w_next_ovf;

endmodule

// File: rtl/interval_meter.sv
// Start/stop interval meter: counts ticks between start and stop, then holds the
// captured interval behind a valid/ack handshake.
module interval_meter
    import interval_meter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_arm,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_tick,
    input  logic         i_ack,
    output logic         o_busy,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_value,
    output logic         o_overflow,
    output logic         o_valid
);

    state_t       r_state;
    logic         r_busy;
    logic [W-1:0] r_value;
    logic         r_overflow;
    logic         r_valid;

    logic         w_clear;
    logic         w_en;
    logic         w_ovf;
    logic [W-1:0] w_next_count;
    logic         w_next_ovf;

    // arm restarts from any state except a pending result, where it needs ack too.
    assign w_clear = (i_arm && (r_state != ST_DONE))
                   || ((r_state == ST_ARMED) && i_start && !i_stop)
                   || ((r_state == ST_DONE) && i_ack && i_arm);
    assign w_en    = (r_state == ST_RUN) && i_tick && !i_arm;

    interval_meter_sat_counter #(.W(W)) u_cnt (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_clear      (w_clear),
        .i_en         (w_en),
        .o_count      (o_count),
        .o_ovf        (w_ovf),
        .o_next_count (w_next_count),
        .o_next_ovf   (w_next_ovf)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_value    <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (i_arm) begin
                        r_state <= ST_ARMED;
                    end else if (i_stop) begin
                        r_value    <= '0;
                        r_overflow <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                    end else if (i_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_arm) begin
                        r_state <= ST_ARMED;
                    end else if (i_stop) begin
                        // The stop-cycle tick is folded into the captured result.
                        r_value    <= w_next_count;
                        r_overflow <= w_next_ovf;
                        r_valid    <= 1'b1;
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (i_ack) begin
                        r_valid <= 1'b0;
                        if (i_arm) begin
                            r_state <= ST_ARMED;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_value    = r_value;
    assign o_overflow = r_overflow;
    assign o_valid    = r_valid;

endmodule

// File: tb/tb_interval_meter.sv
// Bench for interval_meter: W=8 and W=4 instances share stimulus; an unbounded
// tick-count model feeds a result scoreboard and per-cycle output checks.
module tb_interval_meter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arm = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0, ack = 1'b0;

    logic       busy8, ovf8, valid8;
    logic [7:0] count8, value8;
    logic       busy4, ovf4, valid4;
    logic [3:0] count4, value4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    interval_meter #(.W(8)) u_dut8 (
        .i_clock(clk), .i_reset_n(rst_n), .i_arm(arm), .i_start(start), .i_stop(stop),
        .i_tick(tick), .i_ack(ack), .o_busy(busy8), .o_count(count8), .o_value(value8),
        .o_overflow(ovf8), .o_valid(valid8)
    );

    interval_meter #(.W(4)) u_dut4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_arm(arm), .i_start(start), .i_stop(stop),
        .i_tick(tick), .i_ack(ack), .o_busy(busy4), .o_count(count4), .o_value(value4),
        .o_overflow(ovf4), .o_valid(valid4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int t, input int maxv);
        return (t > maxv) ? maxv : t;
    endfunction

    // Reference model: elapsed ticks kept as a plain integer; W only matters
    // when the result is viewed (clamp to 2^W-1, overflow when it exceeds that).
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
    int   ms = M_IDLE;
    int   ticks = 0;
    int   m_cap = 0;
    bit   m_valid = 1'b0;
    int   q8[$];
    int   q4[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms = M_IDLE; ticks = 0; m_cap = 0; m_valid = 1'b0;
            q8.delete(); q4.delete();
        end else begin
            case (ms)
                M_IDLE: if (arm) begin ms = M_ARMED; ticks = 0; end
                M_ARMED: begin
                    if (arm) ticks = 0;
                    else if (stop) begin
                        m_cap = 0; m_valid = 1'b1; ms = M_DONE;
                        q8.push_back(0); q4.push_back(0);
                    end else if (start) begin ms = M_RUN; ticks = 0; end
                end
                M_RUN: begin
                    if (arm) begin ms = M_ARMED; ticks = 0; end
                    else begin
                        if (tick) ticks++;
                        if (stop) begin
                            m_cap = ticks; m_valid = 1'b1; ms = M_DONE;
                            q8.push_back(ticks); q4.push_back(ticks);
                        end
                    end
                end
                default: if (ack) begin
                    m_valid = 1'b0;
                    if (arm) begin ms = M_ARMED; ticks = 0; end
                    else ms = M_IDLE;
                end
            endcase
        end
    end

    // Monitor: live outputs every cycle, scoreboard pop on each new result.
    bit pv8 = 1'b0, pv4 = 1'b0;
    always @(negedge clk) begin
        int t;
        bit m_busy;
        m_busy = (ms == M_ARMED) || (ms == M_RUN);
        chk("busy8", busy8, m_busy);
        chk("busy4", busy4, m_busy);
        chk("valid8", valid8, m_valid);
        chk("valid4", valid4, m_valid);
        chk("count8", count8, clampv(ticks, 255));
        chk("count4", count4, clampv(ticks, 15));
        chk("held_value8", value8, clampv(m_cap, 255));
        chk("held_value4", value4, clampv(m_cap, 15));
        chk("held_ovf8", ovf8, m_cap > 255);
        chk("held_ovf4", ovf4, m_cap > 15);
        if (valid8 && !pv8) begin
            if (q8.size() == 0) chk("unexpected_result8", 1, 0);
            else begin
                t = q8.pop_front();
                chk("result_value8", value8, clampv(t, 255));
                chk("result_ovf8", ovf8, t > 255);
            end
        end
        if (valid4 && !pv4) begin
            if (q4.size() == 0) chk("unexpected_result4", 1, 0);
            else begin
                t = q4.pop_front();
                chk("result_value4", value4, clampv(t, 15));
                chk("result_ovf4", ovf4, t > 15);
            end
        end
        pv8 = valid8;
        pv4 = valid4;
    end

    task automatic step(input bit a, input bit s, input bit p, input bit t, input bit k);
        arm = a; start = s; stop = p; tick = t; ack = k;
        @(negedge clk);
    endtask

    task automatic rnd_step(input bit allow_ack);
        step($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
             allow_ack && ($urandom_range(0, 2) == 0));
    endtask

    initial begin
        // Reset held with random inputs, then idle without arm
        for (int i = 0; i < 3; i++) rnd_step(1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1);

        // Basic 5-tick measurement
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // 20 ticks: saturates the narrow instance; then ack+arm and 3 ticks
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);

        // Start+stop together, then alternating ticks
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);

        // Pending result 7 survives 10 cycles of noise without ack
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) rnd_step(1'b0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Value 3, then reset mid-run at count 9
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count8", count8, 0);
        chk("async_rst_value8", value8, 0);
        chk("async_rst_busy8", busy8, 0);
        chk("async_rst_count4", count4, 0);
        chk("async_rst_valid4", valid4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort during RUN at count 6: back to ARMED, no capture
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) rnd_step(1'b1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
